// File: rtl/fetch_pkg.sv
// Shared constants and F/D bundle for the fetch stage.
// Next-PC select codes match the ones the decoder drives.
package fetch_pkg;

    localparam logic [2:0] NS_PC4 = 3'd0;
    localparam logic [2:0] NS_B   = 3'd1;
    localparam logic [2:0] NS_J   = 3'd2;
    localparam logic [2:0] NS_RS  = 3'd3;

    localparam logic [31:0] INSTR_NOP    = 32'h0;
    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        adel;
    } if_id_t;

endpackage

// File: rtl/fetch_if.sv
// Control, instruction-memory and D-register signals of the fetch stage.
// master = fetch stage, slave = surrounding core / memory.
interface fetch_if #(
    parameter int CNT_W = 32
);
    logic             stall;
    logic             flush_d;
    logic [2:0]       npc_sel;
    logic             b_j;
    logic [31:0]      rs_fwd;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      instr_d;
    logic [31:0]      pc_d;
    logic [31:0]      pc8_d;
    logic             valid_d;
    logic             adel_d;
    logic [CNT_W-1:0] fetch_cnt;

    modport master (
        input  stall, flush_d, npc_sel, b_j, rs_fwd, imem_rdata,
        output imem_addr, instr_d, pc_d, pc8_d, valid_d, adel_d,
        output fetch_cnt
    );

    modport slave (
        output stall, flush_d, npc_sel, b_j, rs_fwd, imem_rdata,
        input  imem_addr, instr_d, pc_d, pc8_d, valid_d, adel_d,
        input  fetch_cnt
    );
endinterface

// File: rtl/fetch_npc.sv
// Next-PC selection from the D-stage jump/branch decision.
// pc_f is the delay-slot address; immediates come from instr_d.
import fetch_pkg::*;

module fetch_npc (
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    input  logic [31:0] instr_d,
    input  logic [2:0]  npc_sel,
    input  logic        b_j,
    input  logic [31:0] rs_fwd,
    output logic [31:0] npc
);
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic        unused_bits;

    assign pc4    = pc_f + 32'd4;
    assign br_off = {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
    assign unused_bits = ^{instr_d[31:26], pc_d[27:0]};

    // Select the redirect target; unknown codes fall through.
    always_comb begin
        npc = pc4;
        unique case (npc_sel)
            NS_B:    npc = b_j ? pc_f + br_off : pc4;
            NS_J:    npc = {pc_d[31:28], instr_d[25:0], 2'b00};
            NS_RS:   npc = rs_fwd;
            default: npc = pc4;
        endcase
    end
endmodule

// File: rtl/fetch_stage.sv
// F stage plus F/D pipeline register with stall and delay-slot flush.
// Optional fetch address check enabled by FETCH_ADEL_EN.
import fetch_pkg::*;

module fetch_stage #(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter int          IM_WORDS = 4096,
    parameter int          CNT_W    = 32
) (
    input logic     clk,
    input logic     reset,
    fetch_if.master bus
);
    logic [31:0]      pc_f;
    logic [31:0]      npc;
    if_id_t           d_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fetch_bad;

    fetch_npc u_npc (
        .pc_f    (pc_f),
        .pc_d    (d_q.pc),
        .instr_d (d_q.instr),
        .npc_sel (bus.npc_sel),
        .b_j     (bus.b_j),
        .rs_fwd  (bus.rs_fwd),
        .npc     (npc)
    );

`ifdef FETCH_ADEL_EN
    localparam logic [32:0] IM_SPAN = 33'(IM_WORDS) << 2;
    logic [32:0] pc_off;

    // Offset wraps huge below PC_RESET, so one compare covers both ends.
    assign pc_off    = {1'b0, pc_f} - {1'b0, PC_RESET};
    assign fetch_bad = (pc_f[1:0] != 2'b00) || (pc_off >= IM_SPAN);
`else
    if (IM_WORDS < 1) begin : g_no_im
    end
    assign fetch_bad = 1'b0;
`endif

    // PC, D register and counter; stall beats flush beats normal fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f  <= PC_RESET;
            d_q   <= '{instr: INSTR_NOP, pc: 32'h0, valid: 1'b0, adel: 1'b0};
            cnt_q <= '0;
        end else if (!bus.stall) begin
            pc_f <= npc;
            if (bus.flush_d) begin
                d_q <= '{instr: INSTR_NOP, pc: pc_f,
                         valid: 1'b0, adel: 1'b0};
            end else begin
                d_q <= '{instr: fetch_bad ? INSTR_NOP : bus.imem_rdata,
                         pc: pc_f, valid: 1'b1, adel: fetch_bad};
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.imem_addr = pc_f;
    assign bus.instr_d   = d_q.instr;
    assign bus.pc_d      = d_q.pc;
    assign bus.pc8_d     = d_q.pc + 32'd8;
    assign bus.valid_d   = d_q.valid;
    assign bus.adel_d    = d_q.adel;
    assign bus.fetch_cnt = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Instruction memory is a small array based at 0x3000.
module tb_fetch_stage;
    logic clk;
    logic reset;
    int   n_run;
    int   n_fail;

    logic [31:0] im [0:127];

    fetch_if #(.CNT_W(32)) bus ();

    fetch_stage #(
        .PC_RESET (32'h0000_3000),
        .IM_WORDS (128),
        .CNT_W    (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory read.
    always_comb begin
        logic [31:0] off;
        off = bus.imem_addr - 32'h3000;
        bus.imem_rdata = 32'h0;
        if (off < 32'd512)
            bus.imem_rdata = im[off[8:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [31:0] pc,
                         input logic [31:0] ins, input logic vld,
                         input logic [31:0] ia, input logic [31:0] cnt);
        chk({tag, ".pc_d"}, bus.pc_d, pc);
        chk({tag, ".instr_d"}, bus.instr_d, ins);
        chk({tag, ".valid_d"}, {31'b0, bus.valid_d}, {31'b0, vld});
        chk({tag, ".imem_addr"}, bus.imem_addr, ia);
        chk({tag, ".fetch_cnt"}, bus.fetch_cnt, cnt);
        chk({tag, ".pc8_d"}, bus.pc8_d, pc + 32'd8);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        for (int i = 0; i < 128; i++)
            im[i] = 32'hA000_0000 | i;
        im[0]  = 32'h3421_0005;
        im[1]  = 32'h0000_0000;
        im[2]  = 32'h1000_FFFE;
        im[4]  = 32'h0800_0C10;
        im[16] = 32'h1111_1111;
        im[64] = 32'h2222_2222;

        bus.stall   = 1'b0;
        bus.flush_d = 1'b0;
        bus.npc_sel = 3'd0;
        bus.b_j     = 1'b0;
        bus.rs_fwd  = 32'h0;
        reset       = 1'b1;
        #2;
        chk_d("reset", 32'h0, 32'h0, 1'b0, 32'h3000, 32'd0);
        chk("reset.adel", {31'b0, bus.adel_d}, 32'h0);
        #10;
        reset = 1'b0;

        tick();
        chk_d("first", 32'h3000, 32'h3421_0005, 1'b1, 32'h3004, 32'd1);
        tick();
        chk_d("seq2", 32'h3004, 32'h0, 1'b1, 32'h3008, 32'd2);
        tick();
        chk_d("beq_in_d", 32'h3008, 32'h1000_FFFE, 1'b1, 32'h300C, 32'd3);

        bus.npc_sel = 3'd1;
        bus.b_j     = 1'b1;
        tick();
        chk_d("beq_taken", 32'h300C, im[3], 1'b1, 32'h3004, 32'd4);
        bus.npc_sel = 3'd0;
        bus.b_j     = 1'b0;
        tick();
        chk_d("tgt", 32'h3004, 32'h0, 1'b1, 32'h3008, 32'd5);
        tick();
        chk_d("beq_again", 32'h3008, 32'h1000_FFFE, 1'b1, 32'h300C, 32'd6);

        bus.npc_sel = 3'd1;
        tick();
        chk_d("beq_not_taken", 32'h300C, im[3], 1'b1, 32'h3010, 32'd7);
        bus.npc_sel = 3'd0;
        tick();
        chk_d("j_in_d", 32'h3010, 32'h0800_0C10, 1'b1, 32'h3014, 32'd8);

        bus.npc_sel = 3'd2;
        tick();
        chk_d("j", 32'h3014, im[5], 1'b1, 32'h3040, 32'd9);
        bus.npc_sel = 3'd3;
        bus.rs_fwd  = 32'h3100;
        tick();
        chk_d("jr", 32'h3040, 32'h1111_1111, 1'b1, 32'h3100, 32'd10);

        bus.npc_sel = 3'd0;
        bus.stall   = 1'b1;
        tick();
        chk_d("stall1", 32'h3040, 32'h1111_1111, 1'b1, 32'h3100, 32'd10);
        bus.flush_d = 1'b1;
        tick();
        chk_d("stall2", 32'h3040, 32'h1111_1111, 1'b1, 32'h3100, 32'd10);
        bus.flush_d = 1'b0;
        tick();
        chk_d("stall3", 32'h3040, 32'h1111_1111, 1'b1, 32'h3100, 32'd10);
        bus.stall = 1'b0;
        tick();
        chk_d("unstall", 32'h3100, 32'h2222_2222, 1'b1, 32'h3104, 32'd11);

        bus.npc_sel = 3'd3;
        bus.rs_fwd  = 32'h3020;
        tick();
        chk_d("jr3020", 32'h3104, im[65], 1'b1, 32'h3020, 32'd12);
        bus.npc_sel = 3'd0;
        tick();
        chk_d("at3020", 32'h3020, im[8], 1'b1, 32'h3024, 32'd13);
        bus.flush_d = 1'b1;
        tick();
        chk_d("flush", 32'h3024, 32'h0, 1'b0, 32'h3028, 32'd13);
        bus.flush_d = 1'b0;
        tick();
        chk_d("post_flush", 32'h3028, im[10], 1'b1, 32'h302C, 32'd14);

        bus.npc_sel = 3'd3;
        bus.rs_fwd  = 32'h3002;
        tick();
        chk_d("jr3002", 32'h302C, im[11], 1'b1, 32'h3002, 32'd15);
        bus.npc_sel = 3'd0;
        tick();
`ifdef FETCH_ADEL_EN
        chk_d("adel", 32'h3002, 32'h0, 1'b1, 32'h3006, 32'd16);
        chk("adel.flag", {31'b0, bus.adel_d}, 32'h1);
`else
        chk_d("adel", 32'h3002, 32'h3421_0005, 1'b1, 32'h3006, 32'd16);
        chk("adel.flag", {31'b0, bus.adel_d}, 32'h0);
`endif

        bus.stall   = 1'b1;
        bus.flush_d = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk_d("reset_mid", 32'h0, 32'h0, 1'b0, 32'h3000, 32'd0);
        chk("reset_mid.adel", {31'b0, bus.adel_d}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
